// File: rtl/icache_pkg.sv
// icache_pkg: shared default geometry, FSM encoding and address-split helpers for the instruction cache
package icache_pkg;
  localparam int IC_LINES = 8;
  localparam int IC_WORDS = 4;
  localparam int IC_AW    = 16;
  localparam int IC_OFF_W = $clog2(IC_WORDS);
  localparam int IC_IDX_W = $clog2(IC_LINES);
  localparam int IC_TAG_W = IC_AW - IC_IDX_W - IC_OFF_W;
  typedef enum logic {LOOKUP, FILL} state_t;
  function automatic logic [31:0] addr_off(logic [31:0] a, int off_w);
    return a & ((32'd1 << off_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_idx(logic [31:0] a, int off_w, int idx_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction
  function automatic logic [31:0] addr_tag(logic [31:0] a, int off_w, int idx_w);
    return a >> (off_w + idx_w);
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: tag/valid/data arrays with one write port and one combinational read port
//   clk, rst_n            : clock, async active-low reset (clears valid bits only)
//   clr_all               : clear every valid bit at the edge
//   wr_en/wr_idx/wr_off   : write wr_data into one word of a line
//   set_en/set_tag        : write the tag of line wr_idx, valid bit <= set_valid
//   rd_idx/rd_tag/rd_off  : lookup; rd_hit and rd_data are combinational
import icache_pkg::*;
module icache_line_store #(
  parameter int LINES = IC_LINES,
  parameter int WORDS = IC_WORDS,
  parameter int TAG_W = IC_TAG_W,
  parameter int IDX_W = $clog2(LINES),
  parameter int OFF_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_all,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [15:0]      wr_data,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_hit,
  output logic [15:0]      rd_data
);
  logic [15:0]      data [LINES][WORDS];
  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  // set after clear so a fill finishing alongside an invalidate still records its tag;
  // the caller drops set_valid in that case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else begin
      if (clr_all) valid <= '0;
      if (set_en) valid[wr_idx] <= set_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) data[wr_idx][wr_off] <= wr_data;
    if (set_en) tags[wr_idx] <= set_tag;
  end
  assign rd_hit  = valid[rd_idx] && tags[rd_idx] == rd_tag;
  assign rd_data = data[rd_idx][rd_off];
endmodule

// File: rtl/icache_fill_unit.sv
// icache_fill_unit: direct-mapped read-only instruction cache with word-by-word line fill
//   clk, rst_n          : clock, async active-low reset
//   cpu_addr/cpu_re     : fetch word address and request
//   cpu_instr/cpu_rdy   : same-cycle hit data (0 unless ready) and ready
//   inv                 : invalidate all lines
//   mem_addr/mem_re     : registered backing-memory read request
//   mem_rdata/mem_valid : backing read data, valid for the current mem_addr
//   miss_cnt            : saturating miss counter
import icache_pkg::*;
module icache_fill_unit #(
  parameter int LINES = IC_LINES,
  parameter int WORDS = IC_WORDS,
  parameter int AW    = IC_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_re,
  output logic [15:0]   cpu_instr,
  output logic          cpu_rdy,
  input  logic          inv,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_valid,
  output logic [15:0]   miss_cnt
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = AW - IDX_W - OFF_W;
  state_t           state, state_n;
  logic [TAG_W-1:0] fill_tag, tag_n;
  logic [IDX_W-1:0] fill_idx, idx_n;
  logic [OFF_W-1:0] fill_cnt, cnt_n;
  logic             kill, kill_n, re_n, wr_en, set_en, hit;
  logic [15:0]      miss_n, rd_data;
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  assign a_tag = TAG_W'(addr_tag(32'(cpu_addr), OFF_W, IDX_W));
  assign a_idx = IDX_W'(addr_idx(32'(cpu_addr), OFF_W, IDX_W));
  assign a_off = OFF_W'(addr_off(32'(cpu_addr), OFF_W));
  icache_line_store #(.LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W)) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_all   (inv),
    .wr_en     (wr_en),
    .wr_idx    (fill_idx),
    .wr_off    (fill_cnt),
    .wr_data   (mem_rdata),
    .set_en    (set_en),
    .set_tag   (fill_tag),
    .set_valid (!kill && !inv),
    .rd_idx    (a_idx),
    .rd_tag    (a_tag),
    .rd_off    (a_off),
    .rd_hit    (hit),
    .rd_data   (rd_data)
  );
  assign cpu_rdy   = cpu_re && hit && state == LOOKUP;
  assign cpu_instr = cpu_rdy ? rd_data : '0;
  // the fill registers are the line base plus beat count, so the concatenation is the registered address
  assign mem_addr  = {fill_tag, fill_idx, fill_cnt};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOOKUP;
      fill_tag <= '0;
      fill_idx <= '0;
      fill_cnt <= '0;
      kill     <= 1'b0;
      mem_re   <= 1'b0;
      miss_cnt <= '0;
    end else begin
      state    <= state_n;
      fill_tag <= tag_n;
      fill_idx <= idx_n;
      fill_cnt <= cnt_n;
      kill     <= kill_n;
      mem_re   <= re_n;
      miss_cnt <= miss_n;
    end
  end
  always_comb begin
    state_n = state;
    tag_n   = fill_tag;
    idx_n   = fill_idx;
    cnt_n   = fill_cnt;
    kill_n  = kill;
    re_n    = mem_re;
    miss_n  = miss_cnt;
    wr_en   = 1'b0;
    set_en  = 1'b0;
    if (state == LOOKUP) begin
      if (cpu_re && !hit && !inv) begin
        state_n = FILL;
        tag_n   = a_tag;
        idx_n   = a_idx;
        cnt_n   = '0;
        kill_n  = 1'b0;
        re_n    = 1'b1;
        miss_n  = &miss_cnt ? miss_cnt : miss_cnt + 16'd1;
      end
    end else begin
      kill_n = kill || inv;
      if (mem_valid) begin
        wr_en = 1'b1;
        cnt_n = fill_cnt + OFF_W'(1);
        if (&fill_cnt) begin
          set_en  = 1'b1;
          state_n = LOOKUP;
          re_n    = 1'b0;
          kill_n  = 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_fill_unit.sv
// tb_icache_fill_unit: directed plus random fetch traffic against a line-level cache model
module tb_icache_fill_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_instr, mem_addr, mem_rdata, miss_cnt;
  logic        cpu_re = 1'b0, cpu_rdy, inv = 1'b0, mem_re, mem_valid, mem_gate = 1'b0;
  int          checks = 0, errors = 0;
  bit          mv[8];
  int          mt[8];
  bit          filling, mkill;
  int          fbase, beats, misses;

  icache_fill_unit dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re),
    .cpu_instr(cpu_instr), .cpu_rdy(cpu_rdy), .inv(inv), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;
  assign mem_valid = mem_re && mem_gate;
  assign mem_rdata = 16'hA000 + mem_addr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mclear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic mreset();
    mclear();
    filling = 1'b0;
    mkill   = 1'b0;
    beats   = 0;
    misses  = 0;
  endtask

  task automatic cyc(bit re, logic [15:0] addr, bit iv, bit gate);
    int  idx, tg;
    bit  hit;
    cpu_re = re; cpu_addr = addr; inv = iv; mem_gate = gate;
    #1;
    idx = (addr >> 2) & 7;
    tg  = addr >> 5;
    hit = re && !filling && mv[idx] && mt[idx] == tg;
    chk("cpu_rdy", cpu_rdy, hit);
    chk("cpu_instr", cpu_instr, hit ? 32'hA000 + addr : 32'd0);
    chk("mem_re", mem_re, filling);
    if (filling) chk("mem_addr", mem_addr, fbase + beats);
    chk("miss_cnt", miss_cnt, misses);
    @(posedge clk);
    if (!filling) begin
      if (iv) mclear();
      if (re && !hit && !iv) begin
        filling = 1'b1;
        fbase   = addr & ~32'd3;
        beats   = 0;
        mkill   = 1'b0;
        if (misses < 65535) misses++;
      end
    end else begin
      if (iv) begin
        mclear();
        mkill = 1'b1;
      end
      if (gate) begin
        beats++;
        if (beats == 4) begin
          filling = 1'b0;
          mt[(fbase >> 2) & 7] = fbase >> 5;
          mv[(fbase >> 2) & 7] = !mkill;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    mreset();
    #1;
    chk("rst_rdy", cpu_rdy, 0);
    chk("rst_instr", cpu_instr, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_miss", miss_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // cold miss: 1 lookup + 4 beats, then hit
    repeat (5) cyc(1, 16'h0012, 0, 1);
    cyc(1, 16'h0012, 0, 1);
    chk("cold_miss_cnt", miss_cnt, 1);
    // line reuse
    cyc(1, 16'h0010, 0, 1);
    cyc(1, 16'h0011, 0, 1);
    cyc(1, 16'h0013, 0, 1);
    // conflict eviction
    repeat (6) cyc(1, 16'h0012, 0, 1);
    repeat (6) cyc(1, 16'h0032, 0, 1);
    repeat (6) cyc(1, 16'h0012, 0, 1);
    chk("conflict_miss_cnt", miss_cnt, 3);
    // wait states and redirect mid-fill
    cyc(0, 16'h0000, 1, 0);
    for (int i = 0; i < 24; i++) cyc(1, i < 3 ? 16'h0010 : 16'h0100, 0, i % 3 == 2);
    chk("redirect_miss_cnt", miss_cnt, 5);
    // invalidate during fill, then invalidate in lookup
    for (int i = 0; i < 12; i++) cyc(1, i < 1 ? 16'h0040 : 16'h0041, i == 2, 1);
    chk("inv_fill_miss_cnt", miss_cnt, 7);
    repeat (6) cyc(1, 16'h0010, 0, 1);
    cyc(1, 16'h0010, 1, 1);
    cyc(1, 16'h0010, 0, 1);
    repeat (4) cyc(1, 16'h0010, 0, 1);
    chk("inv_lookup_miss_cnt", miss_cnt, 9);
    // reset after two fill beats
    cyc(1, 16'h0060, 0, 1);
    cyc(1, 16'h0060, 0, 1);
    cyc(1, 16'h0060, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_re", mem_re, 0);
    chk("midrst_miss", miss_cnt, 0);
    chk("midrst_rdy", cpu_rdy, 0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc(1, 16'h0060, 0, 1);
    chk("refill_miss_cnt", miss_cnt, 1);
    // random traffic
    repeat (800)
      cyc($urandom_range(0, 9) < 8, 16'($urandom_range(0, 511)), $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
